// File: rtl/lvds_frame_capture.sv
// rtl/lvds_frame_capture.sv - multi-lane LVDS deserialiser that writes one frame into a buffer RAM
// Optional early frame end on LVDS_VS deassertion: define LVDS_CAP_SHORT_FRAME_EN.
module lvds_frame_capture #(
   parameter int WORD_W    = 32,
   parameter int LANES     = 1,
   parameter int AW        = 9,
   parameter int DEPTH     = 512,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              LVDS_CLK,
   input  logic              RSTn,
   input  logic              LVDS_VS,
   input  logic [LANES-1:0]  LVDS_DATA,
   input  logic              STATE_CLEAR,
   output logic [AW-1:0]     BUF_WADDR,
   output logic [WORD_W-1:0] BUF_WD,
   output logic              BUF_WEN,
   output logic [1:0]        CAP_STATE,
   output logic [AW:0]       CAP_WORDS
);
   localparam int BEATS = WORD_W / LANES;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
   localparam logic [AW:0]   LAST_WORD = (AW + 1)'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_vs_d;
   logic [BW-1:0]     r_beat;
   logic [WORD_W-1:0] r_shift;

   logic              w_start;
   logic              w_short;
   logic              w_capture;
   logic              w_word_end;
   logic [AW:0]       w_count;
   logic [WORD_W-1:0] w_assembled;

   // The falling-edge cycle itself carries beat 0 of word 0.
   assign w_start    = (r_state == S_IDLE) && r_vs_d && !LVDS_VS;
   assign w_capture  = w_start || ((r_state == S_BUSY) && !w_short);
   assign w_word_end = w_capture && (r_beat == LAST_BEAT);
   assign w_count    = w_start ? '0 : CAP_WORDS;

   always_comb begin
      if (MSB_FIRST)
         w_assembled = (r_shift << LANES) | WORD_W'(LVDS_DATA);
      else
         w_assembled = (r_shift >> LANES) | (WORD_W'(LVDS_DATA) << (WORD_W - LANES));
   end

`ifdef LVDS_CAP_SHORT_FRAME_EN
   logic [WORD_W-1:0] w_partial;

   // Shifting by the missing beat count both aligns the partial word and flushes stale bits.
   assign w_short   = (r_state == S_BUSY) && LVDS_VS;
   assign w_partial = MSB_FIRST ? (r_shift << (LANES * (BEATS - int'(r_beat))))
                                : (r_shift >> (LANES * (BEATS - int'(r_beat))));
`else
   assign w_short = 1'b0;
`endif

   always_ff @(posedge LVDS_CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state   <= S_IDLE;
         r_vs_d    <= 1'b1;
         r_beat    <= '0;
         r_shift   <= '0;
         BUF_WADDR <= '0;
         BUF_WD    <= '0;
         BUF_WEN   <= 1'b0;
         CAP_STATE <= 2'd0;
         CAP_WORDS <= '0;
      end else begin
         r_vs_d  <= LVDS_VS;
         BUF_WEN <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state   <= S_BUSY;
                  CAP_STATE <= 2'd1;
                  CAP_WORDS <= '0;
               end
            end
            S_DONE: begin
               if (STATE_CLEAR) begin
                  r_state   <= S_IDLE;
                  CAP_STATE <= 2'd0;
               end
            end
            default: ;
         endcase

         if (w_capture) begin
            r_shift <= w_assembled;
            r_beat  <= w_word_end ? '0 : r_beat + 1'b1;
            if (w_word_end) begin
               BUF_WEN   <= 1'b1;
               BUF_WADDR <= w_count[AW-1:0];
               BUF_WD    <= w_assembled;
               CAP_WORDS <= w_count + 1'b1;
               if (w_count == LAST_WORD) begin
                  r_state   <= S_DONE;
                  CAP_STATE <= 2'd2;
               end
            end
         end

`ifdef LVDS_CAP_SHORT_FRAME_EN
         if (w_short) begin
            r_state   <= S_DONE;
            CAP_STATE <= 2'd3;
            r_beat    <= '0;
            if (r_beat != '0) begin
               BUF_WEN   <= 1'b1;
               BUF_WADDR <= CAP_WORDS[AW-1:0];
               BUF_WD    <= w_partial;
               CAP_WORDS <= CAP_WORDS + 1'b1;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_lvds_frame_capture.sv
// tb/tb_lvds_frame_capture.sv - scoreboard bench for lvds_frame_capture
// Two instances: default build (1 lane, MSB first) and 4-lane LSB-first with a 4-word frame.
`timescale 1ns/1ps
module tb_lvds_frame_capture;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [8:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t q_a[$];
   wr_t q_b[$];
   wr_t e_a, e_b;
   int  n_cmp = 0;
   int  n_bad = 0;
   int  cyc = 0;
   int  last_a = -1, last_b = -1;
   int  t0_a = 0, t0_b = 0;

   logic        a_rstn, a_vs, a_clr;
   logic [0:0]  a_data;
   logic [8:0]  a_waddr;
   logic [31:0] a_wd;
   logic        a_wen;
   logic [1:0]  a_state;
   logic [9:0]  a_words;

   logic        b_rstn, b_vs, b_clr;
   logic [3:0]  b_data;
   logic [1:0]  b_waddr;
   logic [31:0] b_wd;
   logic        b_wen;
   logic [1:0]  b_state;
   logic [2:0]  b_words;

   lvds_frame_capture u_dut_a (
      .LVDS_CLK(clk), .RSTn(a_rstn), .LVDS_VS(a_vs), .LVDS_DATA(a_data),
      .STATE_CLEAR(a_clr), .BUF_WADDR(a_waddr), .BUF_WD(a_wd), .BUF_WEN(a_wen),
      .CAP_STATE(a_state), .CAP_WORDS(a_words)
   );

   lvds_frame_capture #(
      .WORD_W(32), .LANES(4), .AW(2), .DEPTH(4), .MSB_FIRST(1'b0)
   ) u_dut_b (
      .LVDS_CLK(clk), .RSTn(b_rstn), .LVDS_VS(b_vs), .LVDS_DATA(b_data),
      .STATE_CLEAR(b_clr), .BUF_WADDR(b_waddr), .BUF_WD(b_wd), .BUF_WEN(b_wen),
      .CAP_STATE(b_state), .CAP_WORDS(b_words)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      #1;
      if (a_wen) begin
         if (q_a.size() == 0) check("a_unexpected_wen", a_wen, 0);
         else begin
            e_a = q_a.pop_front();
            check("a_waddr", a_waddr, e_a.addr);
            check("a_wd", a_wd, e_a.data);
         end
         if (last_a >= 0) check("a_wen_period", cyc - last_a, 32);
         last_a = cyc;
      end
   end

   always @(posedge clk) begin
      #1;
      if (b_wen) begin
         if (q_b.size() == 0) check("b_unexpected_wen", b_wen, 0);
         else begin
            e_b = q_b.pop_front();
            check("b_waddr", {7'd0, b_waddr}, e_b.addr);
            check("b_wd", b_wd, e_b.data);
         end
         if (last_b >= 0) check("b_wen_period", cyc - last_b, 8);
         last_b = cyc;
      end
   end

   // Serial MSB-first word on the single lane; expectation queued with the last beat.
   task automatic send_word_a(input logic [31:0] w, input logic [8:0] addr);
      wr_t e;
      for (int b = 31; b >= 0; b--) begin
         @(negedge clk);
         if (b == 31 && addr == 0) t0_a = cyc;
         a_vs   = 1'b0;
         a_data = w[b];
      end
      e.addr = addr;
      e.data = w;
      q_a.push_back(e);
   endtask

   // Nibble k of w goes out on beat k, so the first beat lands in the LSBs.
   task automatic send_word_b(input logic [31:0] w, input logic [8:0] addr, input bit clr_first);
      wr_t e;
      for (int b = 0; b < 8; b++) begin
         @(negedge clk);
         if (b == 0 && addr == 0) t0_b = cyc;
         b_vs   = 1'b0;
         b_data = w[4*b +: 4];
         b_clr  = clr_first && (b == 0);
      end
      b_clr  = 1'b0;
      e.addr = addr;
      e.data = w;
      q_b.push_back(e);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      a_rstn = 1'b0; a_vs = 1'b1; a_data = 1'b0; a_clr = 1'b0;
      b_rstn = 1'b0; b_vs = 1'b1; b_data = 4'h0; b_clr = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_a_wen", a_wen, 0);
      check("rst_a_waddr", a_waddr, 0);
      check("rst_a_wd", a_wd, 0);
      check("rst_a_state", a_state, 0);
      check("rst_a_words", a_words, 0);
      check("rst_b_state", b_state, 0);
      a_rstn = 1'b1;
      b_rstn = 1'b1;
      repeat (2) @(negedge clk);

      // 4-lane frame, with a clear pulse mid-frame that must be ignored
      last_b = -1;
      send_word_b(32'h87654321, 0, 1'b0);
      check("b_state_busy", b_state, 1);
      send_word_b(32'h87654321, 1, 1'b0);
      send_word_b($urandom(), 2, 1'b1);
      send_word_b($urandom(), 3, 1'b0);
      @(posedge clk); #1;
      check("b_final_wen", b_wen, 1);
      check("b_final_state", b_state, 2);
      check("b_final_words", b_words, 4);
      check("b_frame_cycles", cyc - t0_b, 32);

      // Second VS edge while DONE: ignored
      @(negedge clk); b_vs = 1'b1;
      repeat (2) @(negedge clk);
      b_vs = 1'b0;
      repeat (8) begin @(negedge clk); b_data = 4'($urandom()); end
      check("b_done_hold_state", b_state, 2);
      check("b_done_hold_words", b_words, 4);

      // Clear with VS still low: back to idle, no retrigger
      @(negedge clk); b_clr = 1'b1;
      @(posedge clk); #1;
      check("b_clear_state", b_state, 0);
      check("b_clear_words_kept", b_words, 4);
      @(negedge clk); b_clr = 1'b0;
      repeat (8) @(negedge clk);
      check("b_vs_low_no_retrigger", b_state, 0);

      // Fresh edge captures again from address 0
      b_vs = 1'b1;
      repeat (2) @(negedge clk);
      last_b = -1;
      send_word_b($urandom(), 0, 1'b0);
      check("b_restart_words", b_words, 0);
      check("b_restart_state", b_state, 1);
      for (int i = 1; i < 4; i++) send_word_b($urandom(), 9'(i), 1'b0);
      @(posedge clk); #1;
      check("b_restart_final_state", b_state, 2);

      // VS falling in the same cycle as the clear is not an arm
      @(negedge clk); b_vs = 1'b1;
      @(negedge clk); b_clr = 1'b1; b_vs = 1'b0;
      @(posedge clk); #1;
      check("b_clear2_state", b_state, 0);
      @(negedge clk); b_clr = 1'b0;
      repeat (6) @(negedge clk);
      check("b_same_cycle_edge_ignored", b_state, 0);
      check("b_same_cycle_words", b_words, 4);

      // Full default frame: 32-bit counter pattern, MSB first
      last_a = -1;
      for (int i = 0; i < 512; i++) send_word_a(32'(i), 9'(i));
      @(posedge clk); #1;
      check("a_final_wen", a_wen, 1);
      check("a_final_state", a_state, 2);
      check("a_final_words", a_words, 512);
      check("a_frame_cycles", cyc - t0_a, 16384);
      @(negedge clk); a_clr = 1'b1;
      @(posedge clk); #1;
      check("a_clear_state", a_state, 0);
      @(negedge clk); a_clr = 1'b0; a_vs = 1'b1;
      repeat (2) @(negedge clk);

      // Asynchronous reset at word 100, beat 10
      last_a = -1;
      for (int i = 0; i < 100; i++) send_word_a($urandom(), 9'(i));
      for (int b = 0; b < 10; b++) begin @(negedge clk); a_data = 1'($urandom()); end
      @(negedge clk); a_rstn = 1'b0;
      #1;
      check("arst_wen", a_wen, 0);
      check("arst_waddr", a_waddr, 0);
      check("arst_wd", a_wd, 0);
      check("arst_state", a_state, 0);
      check("arst_words", a_words, 0);
      @(negedge clk); a_rstn = 1'b1; a_vs = 1'b1;
      repeat (2) @(negedge clk);
      last_a = -1;
      for (int i = 0; i < 3; i++) send_word_a($urandom(), 9'(i));

`ifdef LVDS_CAP_SHORT_FRAME_EN
      for (int b = 0; b < 8; b++) begin @(negedge clk); a_data = 1'b1; end
      @(negedge clk);
      a_vs   = 1'b1;
      a_data = 1'b0;
      last_a = -1;
      e_a.addr = 9'd3;
      e_a.data = 32'hFF00_0000;
      q_a.push_back(e_a);
      @(posedge clk); #1;
      check("short_wen", a_wen, 1);
      check("short_words", a_words, 4);
      check("short_state", a_state, 3);
      repeat (3) @(negedge clk);
      check("short_state_hold", a_state, 3);
`else
      begin
         wr_t e;
         logic [31:0] w;
         w = $urandom();
         for (int b = 31; b >= 0; b--) begin
            @(negedge clk);
            a_vs   = 1'b1;
            a_data = w[b];
         end
         e.addr = 9'd3;
         e.data = w;
         q_a.push_back(e);
      end
      @(posedge clk); #1;
      check("vs_ignored_wen", a_wen, 1);
      check("vs_ignored_state", a_state, 1);
      check("vs_ignored_words", a_words, 4);
`endif

      repeat (4) @(negedge clk);
      check("q_a_drained", q_a.size(), 0);
      check("q_b_drained", q_b.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
